async_req_arbiter: RTL and testbench
====================================

// Module: async_req_arbiter
// PURPOSE
//  Shares one synchronous valid/ready output stream between NUM_CH independent
//  asynchronous 4-phase req/ack producers (UART RX cores, off-clock sensors).
//  Each channel is synchronized into the clock domain and held until served.
//  A round-robin arbiter forwards one word per grant, tagged with a channel id.
//  Each channel's ack completes only after its word has been accepted downstream.
// PARAMETERS
//  NUM_CH      4   number of async requesters, >=2
//  DATA_WIDTH  8   payload width per channel
//  SYNC_STAGE  2   synchronizer FFs on req/data; 0 = inputs already synchronous
//  ID_WIDTH    2   width of sync_id, $clog2(NUM_CH)
// PORTS
//  clock       in   1                    single clock, all logic posedge
//  reset       in   1                    synchronous, active-high
//  async_req   in   NUM_CH               per-channel 4-phase request, bit i = ch i
//  async_ack   out  NUM_CH               per-channel 4-phase acknowledge
//  async_d     in   NUM_CH*DATA_WIDTH    ch i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  sync_valid  out  1                    output word valid
//  sync_ready  in   1                    downstream ready
//  sync_d      out  DATA_WIDTH           output payload
//  sync_id     out  ID_WIDTH             source channel of sync_d
// BEHAVIOUR
//  Reset: async_ack=0, sync_valid=0, sync_d=0, sync_id=0, every channel IDLE,
//   rr pointer=0, synchronizer and edge FFs cleared. Reset mid-transfer drops any
//   pending or presented word. A req held high across reset is a new request.
//  Per-channel sync: req and data share SYNC_STAGE FFs; req_s = last stage.
//   Edge FF req_dd <= req_s; rise = req_s & ~req_dd.
//  Per-channel FSM:
//   IDLE    : on rise -> PEND; capture synced data into channel hold reg.
//   PEND    : waits for grant; -> SENT when granted.
//   SENT    : word in output reg; on sync_valid&sync_ready with sync_id==i -> ACK,
//             async_ack[i]<=1 the following edge.
//   ACK     : async_ack[i]=1 until req_dd==0; then async_ack[i]<=0 -> IDLE.
//   A rise in any state other than IDLE is impossible under 4-phase and is ignored.
//  Arbiter: output reg free when !sync_valid or (sync_valid & sync_ready).
//   When free and any channel is PEND, grant the first PEND at or after rr_ptr
//   (wrapping NUM_CH-1 -> 0). Next edge: sync_valid=1, sync_d/sync_id loaded,
//   and rr_ptr = granted+1 mod NUM_CH. Accept and new grant in the same cycle
//   give back-to-back valid with no bubble.
//  sync_d/sync_id stable while sync_valid & !sync_ready. A channel never holds
//   two words at once.
//  Latency (SYNC_STAGE=S, idle output): async_req rise -> PEND after S+1 edges;
//   sync_valid 1 edge later; async_ack 1 edge after accept; async_ack falls
//   S+2 edges after async_req falls.
//  SYNC_STAGE=0: req_s=async_req, data direct; otherwise identical.
// STRUCTURE
//  Shared package async_pkg: channel-state localparams (IDLE/PEND/SENT/ACK, 2b)
//   and a clog2 function.
//  Sub-module async_chan_sync: one per channel via generate. Holds synchronizer,
//   edge FF, hold reg and FSM. Ports: grant, accepted, pend, hold_d, ack.
//  Top level: round-robin picker, output reg, rr_ptr.
// TESTING
//  1 single: ch2 req with d=8'hA5, ready=1 -> valid after S+2 edges, d=A5, id=2,
//    ack2 rises 1 edge after accept; req2 low -> ack2 low after S+2 edges.
//  2 simultaneous: ch0..3 req same edge, d=10,11,12,13, ready=1 -> ids 0,1,2,3
//    on consecutive cycles with no bubbles; each ack after its own accept only.
//  3 fairness: ch1 re-requests at once after every ack while ch3 is pending ->
//    ch3 is served within one round (never starved).
//  4 backpressure: ch0 pending, ready=0 for 10 cycles -> valid held, d/id stable,
//    ack0=0; ready=1 -> one accept, ack0 rises the next edge.
//  5 reset mid-op: reset 1 cycle while ch1 is SENT and ch2 is ACK -> all outputs 0;
//    a still-high req1 is re-served after reset release.
//  6 SYNC_STAGE=0 build: repeat test 1 -> valid 2 edges after req rise.

Source files
------------

// File: rtl/async_pkg.sv
// Shared definitions for the async request arbiter: channel states and a
// constant-width helper.
package async_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPend = 2'd1,
        StSent = 2'd2,
        StAck  = 2'd3
    } chan_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/async_chan_sync.sv
// One asynchronous 4-phase producer: synchronizer, rise detector, hold register
// and the IDLE/PEND/SENT/ACK handshake sequencer.
module async_chan_sync
    import async_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SYNC_STAGE = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  grant_i,
    input  logic                  accepted_i,
    output logic                  pend_o,
    output logic [DATA_WIDTH-1:0] hold_d_o,
    output logic                  ack_o
);

    logic                  req_s;
    logic [DATA_WIDTH-1:0] data_s;

    // Data rides the same flops as req so it is settled whenever req_s is.
    if (SYNC_STAGE == 0) begin : g_direct
        assign req_s  = req_i;
        assign data_s = data_i;
    end else begin : g_sync
        logic [DATA_WIDTH:0] sync_q [SYNC_STAGE];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < SYNC_STAGE; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= {req_i, data_i};
                for (int i = 1; i < SYNC_STAGE; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign {req_s, data_s} = sync_q[SYNC_STAGE-1];
    end

    chan_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  req_dd_q;
    logic                  rise;

    assign rise = req_s & ~req_dd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            req_dd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            req_dd_q <= req_s;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPend;
                    hold_d  = data_s;
                end
            end
            StPend: if (grant_i)    state_d = StSent;
            StSent: if (accepted_i) state_d = StAck;
            // Release ack only once the producer's req drop has crossed over.
            StAck:  if (!req_dd_q)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign pend_o   = (state_q == StPend);
    assign ack_o    = (state_q == StAck);
    assign hold_d_o = hold_q;

endmodule

// File: rtl/async_req_arbiter.sv
// Merges NUM_CH asynchronous 4-phase producers into one valid/ready stream,
// round-robin, tagging each word with its source channel.
module async_req_arbiter
    import async_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SYNC_STAGE = 2,
    parameter int unsigned ID_WIDTH   = clog2(NUM_CH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            async_req,
    output logic [NUM_CH-1:0]            async_ack,
    input  logic [NUM_CH*DATA_WIDTH-1:0] async_d,
    output logic                         sync_valid,
    input  logic                         sync_ready,
    output logic [DATA_WIDTH-1:0]        sync_d,
    output logic [ID_WIDTH-1:0]          sync_id
);

    logic [NUM_CH-1:0]                 pend;
    logic [NUM_CH-1:0]                 grant;
    logic [NUM_CH-1:0]                 accepted;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] hold_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        async_chan_sync #(
            .DATA_WIDTH (DATA_WIDTH),
            .SYNC_STAGE (SYNC_STAGE)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .req_i      (async_req[i]),
            .data_i     (async_d[i*DATA_WIDTH +: DATA_WIDTH]),
            .grant_i    (grant[i]),
            .accepted_i (accepted[i]),
            .pend_o     (pend[i]),
            .hold_d_o   (hold_d[i]),
            .ack_o      (async_ack[i])
        );
    end

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ID_WIDTH-1:0]   rr_q, rr_d;
    logic                  out_free;
    logic                  gnt_any;
    logic [ID_WIDTH-1:0]   gnt_idx;

    assign out_free = ~valid_q | sync_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            accepted[i] = valid_q & sync_ready & (id_q == ID_WIDTH'(i));
        end
    end

    // First pending channel at or after rr_q, wrapping.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(rr_q) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!gnt_any && pend[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_WIDTH'(idx);
            end
        end
        if (out_free && gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        d_d     = d_q;
        id_d    = id_q;
        rr_d    = rr_q;
        if (out_free) begin
            valid_d = gnt_any;
            if (gnt_any) begin
                d_d  = hold_d[gnt_idx];
                id_d = gnt_idx;
                rr_d = (gnt_idx == ID_WIDTH'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            d_q     <= '0;
            id_q    <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            d_q     <= d_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    assign sync_valid = valid_q;
    assign sync_d     = d_q;
    assign sync_id    = id_q;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Directed latency/ordering/backpressure/reset scenarios plus a randomized
// 4-phase producer run scored against a per-channel expected-word model.
module tb_async_req_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Two-stage synchronizer build
    logic [NCH-1:0]    a_req, a_ack;
    logic [NCH*DW-1:0] a_d;
    logic              a_valid, a_ready;
    logic [DW-1:0]     a_sd;
    logic [1:0]        a_id;

    // Already-synchronous build
    logic [NCH-1:0]    b_req, b_ack;
    logic [NCH*DW-1:0] b_d;
    logic              b_valid, b_ready;
    logic [DW-1:0]     b_sd;
    logic [1:0]        b_id;

    async_req_arbiter #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .SYNC_STAGE(2), .ID_WIDTH(2)
    ) u_dut_s2 (
        .clock(clock), .reset(reset), .async_req(a_req), .async_ack(a_ack),
        .async_d(a_d), .sync_valid(a_valid), .sync_ready(a_ready),
        .sync_d(a_sd), .sync_id(a_id)
    );

    async_req_arbiter #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .SYNC_STAGE(0), .ID_WIDTH(2)
    ) u_dut_s0 (
        .clock(clock), .reset(reset), .async_req(b_req), .async_ack(b_ack),
        .async_d(b_d), .sync_valid(b_valid), .sync_ready(b_ready),
        .sync_d(b_sd), .sync_id(b_id)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        a_req   = '0;
        b_req   = '0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        reset   = 1'b1;
        ticks(2);
        reset   = 1'b0;
    endtask

    // Scoreboard state
    logic [DW-1:0]  exp_d [NCH];
    int             issued [NCH];
    int             served [NCH];
    logic [NCH-1:0] outstanding;
    logic           pv, pr;
    logic [DW-1:0]  pd;
    logic [1:0]     pid;
    logic [NCH-1:0] pack;
    logic [DW-1:0]  rnd_byte;
    int             ch1_before;
    bit             ch3_done;
    bit             seen;
    bit             draining;

    initial begin
        a_d = '0;
        b_d = '0;

        // Reset state
        do_reset();
        chk("rst_ack", a_ack, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_d", a_sd, 0);
        chk("rst_id", a_id, 0);
        chk("rst_ack_s0", b_ack, 0);
        chk("rst_valid_s0", b_valid, 0);

        // 1: single request on ch2, SYNC_STAGE=2
        a_d[2*DW +: DW] = 8'hA5;
        a_req[2] = 1'b1;
        ticks(3);
        chk("t1_valid_early", a_valid, 0);
        tick();
        chk("t1_valid", a_valid, 1);
        chk("t1_d", a_sd, 8'hA5);
        chk("t1_id", a_id, 2);
        chk("t1_ack_pre", a_ack, 0);
        tick();
        chk("t1_ack_rise", a_ack, 4'b0100);
        chk("t1_valid_drop", a_valid, 0);
        a_req[2] = 1'b0;
        ticks(3);
        chk("t1_ack_held", a_ack, 4'b0100);
        tick();
        chk("t1_ack_fall", a_ack, 0);

        // 6: same on the SYNC_STAGE=0 build
        b_d[2*DW +: DW] = 8'hA5;
        b_req[2] = 1'b1;
        tick();
        chk("t6_valid_early", b_valid, 0);
        tick();
        chk("t6_valid", b_valid, 1);
        chk("t6_d", b_sd, 8'hA5);
        chk("t6_id", b_id, 2);
        tick();
        chk("t6_ack_rise", b_ack, 4'b0100);
        b_req[2] = 1'b0;
        tick();
        chk("t6_ack_held", b_ack, 4'b0100);
        tick();
        chk("t6_ack_fall", b_ack, 0);

        // 2: all channels at once, back-to-back in id order
        do_reset();
        a_d = {8'h13, 8'h12, 8'h11, 8'h10};
        a_req = 4'hF;
        ticks(3);
        chk("t2_valid_early", a_valid, 0);
        for (int k = 0; k < NCH; k++) begin
            tick();
            chk("t2_valid", a_valid, 1);
            chk("t2_id", a_id, k);
            chk("t2_d", a_sd, 32'h10 + k);
            chk("t2_ack", a_ack, (32'd1 << k) - 32'd1);
        end
        tick();
        chk("t2_valid_end", a_valid, 0);
        chk("t2_ack_all", a_ack, 4'hF);
        a_req = '0;
        ticks(4);
        chk("t2_ack_clear", a_ack, 0);

        // 3: ch1 re-requests as fast as 4-phase allows; ch3 must still be served
        do_reset();
        ch1_before = 0;
        ch3_done   = 1'b0;
        a_d[3*DW +: DW] = 8'h33;
        a_req[3] = 1'b1;
        for (int cyc = 0; cyc < 80 && !ch3_done; cyc++) begin
            if (a_req[1] && a_ack[1]) begin
                a_req[1] = 1'b0;
            end else if (!a_req[1] && !a_ack[1]) begin
                a_d[1*DW +: DW] = a_d[1*DW +: DW] + 8'd1;
                a_req[1] = 1'b1;
            end
            if (a_valid && a_ready) begin
                if (a_id == 2'd3) begin
                    ch3_done = 1'b1;
                    chk("t3_ch3_d", a_sd, 8'h33);
                end else if (a_id == 2'd1) begin
                    ch1_before++;
                end
            end
            tick();
        end
        chk("t3_ch3_served", ch3_done, 1);
        chk("t3_one_round", ch1_before <= 1, 1);
        a_req = '0;
        ticks(8);

        // 4: backpressure holds the word
        do_reset();
        a_ready = 1'b0;
        a_d[0 +: DW] = 8'h3C;
        a_req[0] = 1'b1;
        ticks(4);
        chk("t4_valid", a_valid, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_hold_valid", a_valid, 1);
            chk("t4_hold_d", a_sd, 8'h3C);
            chk("t4_hold_id", a_id, 0);
            chk("t4_hold_ack", a_ack, 0);
        end
        a_ready = 1'b1;
        tick();
        chk("t4_valid_drop", a_valid, 0);
        chk("t4_ack_rise", a_ack, 4'b0001);
        a_req = '0;
        ticks(4);

        // 5: reset while ch2 is in ACK and ch1 is presented
        do_reset();
        a_d[2*DW +: DW] = 8'h22;
        a_req[2] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = a_ack[2];
        end
        chk("t5_ack2_up", seen, 1);
        a_ready = 1'b0;
        a_d[1*DW +: DW] = 8'h11;
        a_req[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = a_valid && (a_id == 2'd1);
        end
        chk("t5_ch1_sent", seen, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_ack", a_ack, 0);
        chk("t5_rst_valid", a_valid, 0);
        chk("t5_rst_d", a_sd, 0);
        chk("t5_rst_id", a_id, 0);
        a_ready = 1'b1;
        ticks(3);
        chk("t5_valid_early", a_valid, 0);
        tick();
        chk("t5_reserve_valid", a_valid, 1);
        chk("t5_reserve_id", a_id, 1);
        chk("t5_reserve_d", a_sd, 8'h11);
        tick();
        chk("t5_next_id", a_id, 2);
        chk("t5_next_d", a_sd, 8'h22);
        a_req = '0;
        ticks(8);

        // Randomized producers against the per-channel scoreboard
        do_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            issued[ch] = 0;
            served[ch] = 0;
            exp_d[ch]  = '0;
        end
        outstanding = '0;
        pv   = 1'b0;
        pr   = 1'b1;
        pd   = '0;
        pid  = '0;
        pack = '0;
        for (int cyc = 0; cyc < 2100; cyc++) begin
            draining = (cyc >= 2000);
            a_ready  = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
            for (int ch = 0; ch < NCH; ch++) begin
                if (a_req[ch] && a_ack[ch]) begin
                    if ($urandom_range(0, 3) == 0) a_req[ch] = 1'b0;
                end else if (!a_req[ch] && !a_ack[ch] && !draining &&
                             $urandom_range(0, 7) == 0) begin
                    rnd_byte = DW'($urandom);
                    a_d[ch*DW +: DW] = rnd_byte;
                    exp_d[ch]       = rnd_byte;
                    issued[ch]++;
                    outstanding[ch] = 1'b1;
                    a_req[ch]       = 1'b1;
                end
            end
            if (pv && !pr) begin
                chk("rnd_stall_valid", a_valid, 1);
                chk("rnd_stall_d", a_sd, pd);
                chk("rnd_stall_id", a_id, pid);
            end
            for (int ch = 0; ch < NCH; ch++) begin
                if (a_ack[ch] && !pack[ch]) begin
                    chk("rnd_ack_after_accept", served[ch], issued[ch]);
                end
            end
            if (a_valid && a_ready) begin
                chk("rnd_outstanding", outstanding[a_id], 1);
                chk("rnd_data", a_sd, exp_d[a_id]);
                served[a_id]++;
                outstanding[a_id] = 1'b0;
            end
            pv   = a_valid;
            pr   = a_ready;
            pd   = a_sd;
            pid  = a_id;
            pack = a_ack;
            tick();
        end
        for (int ch = 0; ch < NCH; ch++) begin
            chk("rnd_served_all", served[ch], issued[ch]);
        end
        chk("rnd_end_valid", a_valid, 0);
        chk("rnd_end_ack", a_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
